// File: rtl/psr_pkg.sv
// psr_pkg: shared definitions for the processor status register block.
//   - Flag bit positions within the status register (C, Z, I, D, B, U, V, N).
//   - Default reset value and pop keep-mask for an 8-bit status register.
//   - Packed record for the sticky stack error flags.
package psr_pkg;

  localparam int PSR_C = 0;  // carry
  localparam int PSR_Z = 1;  // zero
  localparam int PSR_I = 2;  // interrupt disable
  localparam int PSR_D = 3;  // decimal
  localparam int PSR_B = 4;  // break
  localparam int PSR_U = 5;  // unused / always-one on most cores
  localparam int PSR_V = 6;  // overflow
  localparam int PSR_N = 7;  // negative

  // Interrupt-disable and the unused bit come up set.
  localparam logic [7:0] PSR_RESET_VAL = 8'h24;
  // B and U describe the current context, not the saved one, so a restore
  // leaves them alone.
  localparam logic [7:0] PSR_KEEP_MASK = 8'h30;

  typedef struct packed {
    logic ovf;   // push attempted while full
    logic unf;   // pop attempted while empty
    logic coll;  // push and pop requested together
  } psr_err_t;

endpackage

// File: rtl/busInterface.sv
// busInterface: output gate onto the internal data bus.
//   i_oe   : drive enable
//   i_data : value to present
//   o_data : i_data when i_oe=1, otherwise all zeros (wired-OR friendly bus)
module busInterface #(
  parameter int WIDTH = 8
) (
  input  logic             i_oe,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  assign o_data = i_oe ? i_data : '0;

endmodule

// File: rtl/psr_lifo.sv
// psr_lifo: storage for saved status-register values.
//   clk, rst : clock and synchronous active-high reset (clears the count only)
//   i_push   : qualified push (caller guarantees not full, not with pop)
//   i_pop    : qualified pop  (caller guarantees not empty, not with push)
//   i_data   : value written at index o_count on push
//   o_top    : entry at index o_count-1 (meaningless while empty)
//   o_count  : number of occupied entries
//   o_full   : o_count == DEPTH
//   o_empty  : o_count == 0
module psr_lifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_top,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0] r_count;
  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_rd_idx;

  // Count is below DEPTH whenever a push is accepted, so the low bits are
  // a valid write index; the read index wraps harmlessly when empty.
  assign w_wr_idx = r_count[IDX_W-1:0];
  assign w_rd_idx = w_wr_idx - IDX_W'(1);

  // The pop result must reach the live register in the same cycle, so the
  // top entry is read asynchronously (small distributed array).
  assign o_top   = r_mem[w_rd_idx];
  assign o_count = r_count;
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);

  // Entries are never reset; anything above the count is unobservable.
  always_ff @(posedge clk) begin
    if (!rst && i_push) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_push) begin
      r_count <= r_count + CNT_W'(1);
    end else if (i_pop) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/psr_shadow_stack.sv
// psr_shadow_stack: live status register with a small save/restore stack.
//   clk, rst        : clock, synchronous active-high reset
//   db_in/db_wr_mask: per-bit load from the internal data bus
//   set_mask        : per-bit force to 1
//   clr_mask        : per-bit force to 0
//   alu_flags/mask  : per-bit load from the ALU
//   push / pop      : save live value / restore from stack top
//   db_oe           : drive live value onto psr_db
//   psr_rcl         : live register
//   psr_db          : live register gated by db_oe
//   depth_cnt       : occupied stack entries; full / empty derived from it
//   err_ovf/unf/coll: sticky push-when-full / pop-when-empty / push+pop
module psr_shadow_stack
  import psr_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = PSR_RESET_VAL,
  parameter logic [WIDTH-1:0] KEEP_MASK = PSR_KEEP_MASK
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       db_in,
  input  logic [WIDTH-1:0]       db_wr_mask,
  input  logic [WIDTH-1:0]       set_mask,
  input  logic [WIDTH-1:0]       clr_mask,
  input  logic [WIDTH-1:0]       alu_flags,
  input  logic [WIDTH-1:0]       alu_mask,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   db_oe,
  output logic [WIDTH-1:0]       psr_rcl,
  output logic [WIDTH-1:0]       psr_db,
  output logic [$clog2(DEPTH):0] depth_cnt,
  output logic                   full,
  output logic                   empty,
  output logic                   err_ovf,
  output logic                   err_unf,
  output logic                   err_coll
);

  logic [WIDTH-1:0]       r_psr;
  psr_err_t               r_err;
  logic [WIDTH-1:0]       w_psr_next;
  logic [WIDTH-1:0]       w_top;
  logic [$clog2(DEPTH):0] w_count;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push_ok;
  logic                   w_pop_ok;

  // A simultaneous push and pop is a collision: neither takes effect.
  assign w_push_ok = push & ~pop & ~w_full;
  assign w_pop_ok  = pop & ~push & ~w_empty;

  psr_lifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_lifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push_ok),
    .i_pop   (w_pop_ok),
    .i_data  (r_psr),      // pre-edge live value, unaffected by this cycle's writes
    .o_top   (w_top),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Per-bit source select: restore > bus > clear > set > ALU > hold.
  // Kept bits skip the restore term and fall through to the rest.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign w_psr_next[gi] = (w_pop_ok && !KEEP_MASK[gi]) ? w_top[gi]     :
                            db_wr_mask[gi]               ? db_in[gi]     :
                            clr_mask[gi]                 ? 1'b0          :
                            set_mask[gi]                 ? 1'b1          :
                            alu_mask[gi]                 ? alu_flags[gi] :
                                                           r_psr[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_psr <= RESET_VAL;
    end else begin
      r_psr <= w_psr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= '0;
    end else begin
      if (push && !pop && w_full)  r_err.ovf  <= 1'b1;
      if (pop && !push && w_empty) r_err.unf  <= 1'b1;
      if (push && pop)             r_err.coll <= 1'b1;
    end
  end

  busInterface #(
    .WIDTH (WIDTH)
  ) u_bus (
    .i_oe   (db_oe),
    .i_data (r_psr),
    .o_data (psr_db)
  );

  assign psr_rcl   = r_psr;
  assign depth_cnt = w_count;
  assign full      = w_full;
  assign empty     = w_empty;
  assign err_ovf   = r_err.ovf;
  assign err_unf   = r_err.unf;
  assign err_coll  = r_err.coll;

endmodule

// File: tb/tb_psr_shadow_stack.sv
// tb_psr_shadow_stack: scoreboard bench for psr_shadow_stack (default params).
module tb_psr_shadow_stack;

  localparam logic [7:0] RST_V = 8'h24;
  localparam logic [7:0] KEEP  = 8'h30;

  logic       clk = 1'b0;
  logic       rst, push, pop, db_oe;
  logic [7:0] db_in, db_wr_mask, set_mask, clr_mask, alu_flags, alu_mask;
  logic [7:0] psr_rcl, psr_db;
  logic [2:0] depth_cnt;
  logic       full, empty, err_ovf, err_unf, err_coll;

  always #5 clk = ~clk;

  psr_shadow_stack dut (
    .clk        (clk),
    .rst        (rst),
    .db_in      (db_in),
    .db_wr_mask (db_wr_mask),
    .set_mask   (set_mask),
    .clr_mask   (clr_mask),
    .alu_flags  (alu_flags),
    .alu_mask   (alu_mask),
    .push       (push),
    .pop        (pop),
    .db_oe      (db_oe),
    .psr_rcl    (psr_rcl),
    .psr_db     (psr_db),
    .depth_cnt  (depth_cnt),
    .full       (full),
    .empty      (empty),
    .err_ovf    (err_ovf),
    .err_unf    (err_unf),
    .err_coll   (err_coll)
  );

  typedef struct packed {
    logic [7:0] psr;
    logic [7:0] db;
    logic [2:0] cnt;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       unf;
    logic       coll;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  // reference model state
  logic [7:0] m_psr;
  logic [7:0] m_stk [4];
  int         m_cnt;
  logic       m_ovf, m_unf, m_coll;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_cycle(input string tag, input logic r, input logic pu, input logic po,
                          input logic oe, input logic [7:0] d, input logic [7:0] dm,
                          input logic [7:0] sm, input logic [7:0] cm,
                          input logic [7:0] af, input logic [7:0] am);
    exp_t       e;
    logic [7:0] top, nxt;
    bit         push_ok, pop_ok;
    @(negedge clk);
    rst = r; push = pu; pop = po; db_oe = oe;
    db_in = d; db_wr_mask = dm; set_mask = sm; clr_mask = cm;
    alu_flags = af; alu_mask = am;
    if (r) begin
      m_psr = RST_V; m_cnt = 0; m_ovf = 0; m_unf = 0; m_coll = 0;
    end else begin
      push_ok = pu && !po && (m_cnt < 4);
      pop_ok  = po && !pu && (m_cnt > 0);
      top     = (m_cnt > 0) ? m_stk[m_cnt-1] : 8'h00;
      for (int b = 0; b < 8; b++) begin
        if (pop_ok && !KEEP[b]) nxt[b] = top[b];
        else if (dm[b])         nxt[b] = d[b];
        else if (cm[b])         nxt[b] = 1'b0;
        else if (sm[b])         nxt[b] = 1'b1;
        else if (am[b])         nxt[b] = af[b];
        else                    nxt[b] = m_psr[b];
      end
      if (pu && !po && m_cnt == 4) m_ovf  = 1'b1;
      if (po && !pu && m_cnt == 0) m_unf  = 1'b1;
      if (pu && po)                m_coll = 1'b1;
      if (push_ok) begin
        m_stk[m_cnt] = m_psr;
        m_cnt++;
      end
      if (pop_ok) m_cnt--;
      m_psr = nxt;
    end
    e.psr   = m_psr;
    e.db    = oe ? m_psr : 8'h00;
    e.cnt   = 3'(m_cnt);
    e.full  = (m_cnt == 4);
    e.empty = (m_cnt == 0);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    e.coll  = m_coll;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_val({tag, ".sb_size"}, 32'(sb_q.size()), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val({tag, ".psr_rcl"},  32'(psr_rcl),   32'(e.psr));
      check_val({tag, ".psr_db"},   32'(psr_db),    32'(e.db));
      check_val({tag, ".depth"},    32'(depth_cnt), 32'(e.cnt));
      check_val({tag, ".full"},     32'(full),      32'(e.full));
      check_val({tag, ".empty"},    32'(empty),     32'(e.empty));
      check_val({tag, ".err_ovf"},  32'(err_ovf),   32'(e.ovf));
      check_val({tag, ".err_unf"},  32'(err_unf),   32'(e.unf));
      check_val({tag, ".err_coll"}, 32'(err_coll),  32'(e.coll));
    end
    $display("txn %-12s rst=%0b push=%0b pop=%0b oe=%0b psr=%02h db=%02h cnt=%0d f=%0b e=%0b err=%0b%0b%0b",
             tag, r, pu, po, oe, psr_rcl, psr_db, depth_cnt, full, empty, err_ovf, err_unf, err_coll);
  endtask

  task automatic idle(input string tag, input logic pu, input logic po);
    do_cycle(tag, 1'b0, pu, po, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic wr_db(input string tag, input logic [7:0] v, input logic pu);
    do_cycle(tag, 1'b0, pu, 1'b0, 1'b0, v, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
  endtask

  logic [7:0] lifo_exp [4];
  logic [7:0] saved;

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state, bus gated off then on
    do_cycle("reset", 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00);
    check_val("rst.psr", 32'(psr_rcl), 32'h24);
    check_val("rst.cnt", 32'(depth_cnt), 32'd0);
    check_val("rst.empty", 32'(empty), 32'd1);
    do_cycle("reset_oe", 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    check_val("rst.db", 32'(psr_db), 32'h24);

    // bus beats set
    do_cycle("db_vs_set", 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, 8'hFF, 8'h04, 8'h00, 8'h00, 8'h00);
    check_val("db_vs_set.v", 32'(psr_rcl), 32'hC3);
    // clear beats set: bits 0,1 cleared, bits 2,3 set
    do_cycle("clr_vs_set", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h0F, 8'h03, 8'h00, 8'h00);
    check_val("clr_vs_set.v", 32'(psr_rcl), 32'hCC);
    // set beats ALU on bit 4; ALU loads 0 into bit 5
    do_cycle("set_vs_alu", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h30);
    check_val("set_vs_alu.v", 32'(psr_rcl), 32'hDC);

    // save 81, overwrite with 02, restore; bits 4,5 come from live (0)
    wr_db("ld81", 8'h81, 1'b0);
    idle("push81", 1'b1, 1'b0);
    wr_db("ld02", 8'h02, 1'b0);
    idle("pop81", 1'b0, 1'b1);
    check_val("restore.v", 32'(psr_rcl), 32'h81);

    // five pushes, each with a same-cycle bus write that must not be saved
    lifo_exp[0] = 8'h81;
    for (int i = 0; i < 5; i++) begin
      wr_db("push_n", 8'hA0 + 8'(i), 1'b1);
      if (i < 3) lifo_exp[i+1] = 8'hA0 + 8'(i);
      if (i == 3) check_val("full_after4", 32'(full), 32'd1);
    end
    check_val("ovf.v", 32'(err_ovf), 32'd1);
    check_val("ovf.cnt", 32'(depth_cnt), 32'd4);
    for (int i = 3; i >= 0; i--) begin
      idle("pop_n", 1'b0, 1'b1);
      check_val("lifo_order", 32'(psr_rcl & ~KEEP), 32'(lifo_exp[i] & ~KEEP));
    end

    // underflow leaves live value alone; collision leaves count alone
    saved = psr_rcl;
    idle("pop_empty", 1'b0, 1'b1);
    check_val("unf.v", 32'(err_unf), 32'd1);
    check_val("unf.psr", 32'(psr_rcl), 32'(saved));
    idle("push1", 1'b1, 1'b0);
    idle("collide", 1'b1, 1'b1);
    check_val("coll.v", 32'(err_coll), 32'd1);
    check_val("coll.cnt", 32'(depth_cnt), 32'd1);

    // reset mid-sequence with a push pending
    idle("push2", 1'b1, 1'b0);
    idle("push3", 1'b1, 1'b0);
    check_val("pre_rst.cnt", 32'(depth_cnt), 32'd3);
    do_cycle("mid_rst", 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
    check_val("mid_rst.empty", 32'(empty), 32'd1);
    check_val("mid_rst.psr", 32'(psr_rcl), 32'h24);
    check_val("mid_rst.errs", 32'({err_ovf, err_unf, err_coll}), 32'd0);

    // random traffic against the model
    for (int n = 0; n < 80; n++) begin
      do_cycle("rand", ($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
               8'($urandom), 8'($urandom & $urandom), 8'($urandom & $urandom),
               8'($urandom & $urandom), 8'($urandom), 8'($urandom & $urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
